adc_sample_averager: RTL and testbench

- Sits between the SPI ADC interface and the ADC normalizer in the voltmeter datapath.
- Discards a fixed number of post-reset settling samples, then block-averages 2^LOG2_N consecutive raw ADC words.
- Emits each decimated average with a one-cycle valid strobe.
- Also tracks running min/max and a sticky full-scale (overrange) flag for the display logic.

---
 rtl/adc_sample_averager.sv | 123 ++++++++++++
 tb/tb_adc_sample_averager.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_averager.sv
// adc_sample_averager: discards post-reset settling samples, then block-averages
// 2^LOG2_N accepted ADC words into a decimated output with a one-cycle strobe.
// Also keeps running min/max and a sticky full-scale flag for the display.
module adc_sample_averager #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 4,
    parameter int SETTLE = 8
) (
    input  logic              clk_2Mhz,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              hold,
    input  logic              peak_clear,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
    output logic              overrange,
    output logic              settled
);

    localparam int ACC_W  = DATA_W + LOG2_N;
    localparam int SCNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    localparam logic [SCNT_W-1:0] SETTLE_LAST = (SETTLE == 0) ? '0 : SCNT_W'(SETTLE - 1);
    localparam logic [SCNT_W-1:0] SCNT_ONE    = SCNT_W'(1);
    localparam logic [LOG2_N-1:0] WIN_ONE     = LOG2_N'(1);

    typedef enum logic {
        S_SETTLE = 1'b0,
        S_ACCUM  = 1'b1
    } state_t;

    state_t             state;
    logic [SCNT_W-1:0]  settle_cnt;
    logic [LOG2_N-1:0]  win_cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   window_sum;
    logic               accepted;

    // Running sum including the current sample; the Nth sample's average comes from this.
    always_comb begin
        window_sum = acc + ACC_W'(sample_in);
        accepted   = (state == S_ACCUM) && sample_valid;
    end

    // Settling/averaging FSM, window accumulator and averaged output.
    always_ff @(posedge clk_2Mhz) begin
        if (reset) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
            win_cnt    <= '0;
            acc        <= '0;
            avg_out    <= '0;
            avg_valid  <= 1'b0;
            settled    <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            case (state)
                S_SETTLE: begin
                    if (SETTLE == 0) begin
                        state   <= S_ACCUM;
                        settled <= 1'b1;
                    end else if (sample_valid) begin
                        settle_cnt <= settle_cnt + SCNT_ONE;
                        if (settle_cnt == SETTLE_LAST) begin
                            state   <= S_ACCUM;
                            settled <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (sample_valid) begin
                        if (win_cnt == '1) begin
                            // Window closes regardless of hold; hold only suppresses publishing.
                            if (!hold) begin
                                avg_out   <= window_sum[ACC_W-1:LOG2_N];
                                avg_valid <= 1'b1;
                            end
                            acc     <= '0;
                            win_cnt <= '0;
                        end else begin
                            acc     <= window_sum;
                            win_cnt <= win_cnt + WIN_ONE;
                        end
                    end
                end
                default: state <= S_SETTLE;
            endcase
        end
    end

    // Peak and overrange tracking over samples accepted after settling.
    always_ff @(posedge clk_2Mhz) begin
        if (reset) begin
            max_out   <= '0;
            min_out   <= '1;
            overrange <= 1'b0;
        end else if (peak_clear) begin
            if (accepted) begin
                max_out   <= sample_in;
                min_out   <= sample_in;
                overrange <= (sample_in == '1);
            end else begin
                max_out   <= '0;
                min_out   <= '1;
                overrange <= 1'b0;
            end
        end else if (accepted) begin
            if (sample_in > max_out) begin
                max_out <= sample_in;
            end
            if (sample_in < min_out) begin
                min_out <= sample_in;
            end
            if (sample_in == '1) begin
                overrange <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench for adc_sample_averager with N=4 and two settling samples.
module tb_adc_sample_averager;

    localparam int DW     = 16;
    localparam int NWIN   = 4;
    localparam int NSET   = 2;

    logic          clk_2Mhz = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          hold = 1'b0;
    logic          peak_clear = 1'b0;
    logic [DW-1:0] avg_out;
    logic          avg_valid;
    logic [DW-1:0] max_out;
    logic [DW-1:0] min_out;
    logic          overrange;
    logic          settled;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (behavioural, sample-list based)
    int unsigned m_settle_seen;
    bit          m_settled;
    int unsigned m_win[$];
    int unsigned m_avg;
    bit          m_avg_valid;
    int unsigned m_max;
    int unsigned m_min;
    bit          m_over;

    adc_sample_averager #(
        .DATA_W(DW),
        .LOG2_N(2),
        .SETTLE(NSET)
    ) dut (
        .clk_2Mhz    (clk_2Mhz),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .hold        (hold),
        .peak_clear  (peak_clear),
        .avg_out     (avg_out),
        .avg_valid   (avg_valid),
        .max_out     (max_out),
        .min_out     (min_out),
        .overrange   (overrange),
        .settled     (settled)
    );

    always #5 clk_2Mhz = ~clk_2Mhz;

    task automatic model_step(input bit r, input bit v, input int unsigned s,
                              input bit h, input bit pc);
        bit acc_ok;
        int unsigned sum;
        if (r) begin
            m_settle_seen = 0;
            m_settled     = 0;
            m_win.delete();
            m_avg         = 0;
            m_avg_valid   = 0;
            m_max         = 0;
            m_min         = 16'hFFFF;
            m_over        = 0;
        end else begin
            acc_ok      = m_settled && v;
            m_avg_valid = 0;
            if (!m_settled) begin
                if (v) m_settle_seen++;
                if (m_settle_seen >= NSET) m_settled = 1;
            end
            if (acc_ok) begin
                m_win.push_back(s);
                if (m_win.size() == NWIN) begin
                    sum = 0;
                    foreach (m_win[i]) sum += m_win[i];
                    if (!h) begin
                        m_avg       = sum / NWIN;
                        m_avg_valid = 1;
                    end
                    m_win.delete();
                end
            end
            if (pc) begin
                if (acc_ok) begin
                    m_max  = s;
                    m_min  = s;
                    m_over = (s == 16'hFFFF);
                end else begin
                    m_max  = 0;
                    m_min  = 16'hFFFF;
                    m_over = 0;
                end
            end else if (acc_ok) begin
                if (s > m_max) m_max = s;
                if (s < m_min) m_min = s;
                if (s == 16'hFFFF) m_over = 1;
            end
        end
    endtask

    // One clock: drive on the falling edge, step the model at the rising edge, return 1 time unit later.
    task automatic tick(input bit r, input bit v, input logic [DW-1:0] s,
                        input bit h, input bit pc);
        @(negedge clk_2Mhz);
        reset        = r;
        sample_valid = v;
        sample_in    = s;
        hold         = h;
        peak_clear   = pc;
        @(posedge clk_2Mhz);
        model_step(r, v, s, h, pc);
        #1;
    endtask

    task automatic test_reset_settle_first_window();
        logic [DW-1:0] seq [4];
        seq = '{16'd100, 16'd200, 16'd300, 16'd400};
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        n_cmp++; if (avg_out !== 16'h0000) begin n_err++; $display("FAIL rst_avg got %h want 0000", avg_out); end
        n_cmp++; if (avg_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", avg_valid); end
        n_cmp++; if (max_out !== 16'h0000) begin n_err++; $display("FAIL rst_max got %h want 0000", max_out); end
        n_cmp++; if (min_out !== 16'hFFFF) begin n_err++; $display("FAIL rst_min got %h want ffff", min_out); end
        n_cmp++; if (overrange !== 1'b0 || settled !== 1'b0) begin n_err++; $display("FAIL rst_flags got over=%b settled=%b want 0 0", overrange, settled); end
        tick(0, 1, 16'hFFFF, 0, 0);
        n_cmp++; if (settled !== 1'b0 || overrange !== 1'b0 || avg_valid !== 1'b0) begin n_err++; $display("FAIL settle1 got settled=%b over=%b valid=%b want 0 0 0", settled, overrange, avg_valid); end
        tick(0, 1, 16'hFFFF, 0, 0);
        n_cmp++; if (settled !== 1'b1 || overrange !== 1'b0 || avg_valid !== 1'b0) begin n_err++; $display("FAIL settle2 got settled=%b over=%b valid=%b want 1 0 0", settled, overrange, avg_valid); end
        n_cmp++; if (max_out !== 16'h0000 || min_out !== 16'hFFFF) begin n_err++; $display("FAIL settle_peak got max=%h min=%h want 0000 ffff", max_out, min_out); end
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, seq[i], 0, 0);
            if (i < 3) begin
                n_cmp++; if (avg_valid !== 1'b0) begin n_err++; $display("FAIL w1_early_valid[%0d] got %b want 0", i, avg_valid); end
            end
        end
        n_cmp++; if (avg_valid !== 1'b1 || avg_out !== 16'd250) begin n_err++; $display("FAIL w1_avg got valid=%b avg=%0d want 1 250", avg_valid, avg_out); end
        n_cmp++; if (max_out !== 16'd400 || min_out !== 16'd100) begin n_err++; $display("FAIL w1_peak got max=%0d min=%0d want 400 100", max_out, min_out); end
        tick(0, 0, 0, 0, 0);
        n_cmp++; if (avg_valid !== 1'b0 || avg_out !== 16'd250) begin n_err++; $display("FAIL w1_pulse_width got valid=%b avg=%0d want 0 250", avg_valid, avg_out); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] seq [4];
        seq = '{16'd1, 16'd1, 16'd1, 16'd2};
        foreach (seq[i]) tick(0, 1, seq[i], 0, 0);
        n_cmp++; if (avg_valid !== 1'b1 || avg_out !== 16'd1) begin n_err++; $display("FAIL trunc_avg got valid=%b avg=%0d want 1 1", avg_valid, avg_out); end
        for (int i = 0; i < 4; i++) tick(0, 1, 16'hFFFF, 0, 0);
        n_cmp++; if (avg_valid !== 1'b1 || avg_out !== 16'hFFFF || overrange !== 1'b1) begin n_err++; $display("FAIL fs_avg got valid=%b avg=%h over=%b want 1 ffff 1", avg_valid, avg_out, overrange); end
        tick(0, 1, 16'd7, 0, 0);
        n_cmp++; if (avg_valid !== 1'b0 || avg_out !== 16'hFFFF) begin n_err++; $display("FAIL b2b_first got valid=%b avg=%h want 0 ffff", avg_valid, avg_out); end
        for (int i = 0; i < 3; i++) tick(0, 1, 16'd7, 0, 0);
        n_cmp++; if (avg_valid !== 1'b1 || avg_out !== 16'd7) begin n_err++; $display("FAIL b2b_window got valid=%b avg=%0d want 1 7", avg_valid, avg_out); end
    endtask

    task automatic test_hold();
        logic [DW-1:0] seq [4];
        seq = '{16'd10, 16'd20, 16'd30, 16'd40};
        foreach (seq[i]) begin
            tick(0, 1, seq[i], 1, 0);
            n_cmp++; if (avg_valid !== 1'b0 || avg_out !== 16'd7) begin n_err++; $display("FAIL hold[%0d] got valid=%b avg=%0d want 0 7", i, avg_valid, avg_out); end
        end
        for (int i = 0; i < 4; i++) tick(0, 1, 16'd4, 0, 0);
        n_cmp++; if (avg_valid !== 1'b1 || avg_out !== 16'd4) begin n_err++; $display("FAIL unhold got valid=%b avg=%0d want 1 4", avg_valid, avg_out); end
    endtask

    task automatic test_mid_window_reset();
        tick(0, 1, 16'd500, 0, 0);
        tick(0, 1, 16'd500, 0, 0);
        tick(1, 0, 0, 0, 0);
        n_cmp++; if (avg_out !== 16'h0000 || min_out !== 16'hFFFF || max_out !== 16'h0000) begin n_err++; $display("FAIL midrst_state got avg=%h min=%h max=%h want 0000 ffff 0000", avg_out, min_out, max_out); end
        n_cmp++; if (settled !== 1'b0 || avg_valid !== 1'b0) begin n_err++; $display("FAIL midrst_flags got settled=%b valid=%b want 0 0", settled, avg_valid); end
        tick(0, 1, 16'd3, 0, 0);
        tick(0, 1, 16'd3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 16'd8, 0, 0);
            if (i < 3) begin
                n_cmp++; if (avg_valid !== 1'b0) begin n_err++; $display("FAIL midrst_early[%0d] got %b want 0", i, avg_valid); end
            end
        end
        n_cmp++; if (avg_valid !== 1'b1 || avg_out !== 16'd8) begin n_err++; $display("FAIL midrst_avg got valid=%b avg=%0d want 1 8", avg_valid, avg_out); end
    endtask

    task automatic test_peak_clear();
        logic [DW-1:0] seq [4];
        seq = '{16'd100, 16'd400, 16'd200, 16'd300};
        tick(0, 0, 0, 0, 1);
        foreach (seq[i]) tick(0, 1, seq[i], 0, 0);
        n_cmp++; if (max_out !== 16'd400 || min_out !== 16'd100 || avg_out !== 16'd250) begin n_err++; $display("FAIL pc_pre got max=%0d min=%0d avg=%0d want 400 100 250", max_out, min_out, avg_out); end
        tick(0, 1, 16'hFFFF, 0, 0);
        n_cmp++; if (overrange !== 1'b1 || max_out !== 16'hFFFF) begin n_err++; $display("FAIL pc_over got over=%b max=%h want 1 ffff", overrange, max_out); end
        tick(0, 0, 0, 0, 1);
        n_cmp++; if (max_out !== 16'h0000 || min_out !== 16'hFFFF || overrange !== 1'b0) begin n_err++; $display("FAIL pc_alone got max=%h min=%h over=%b want 0000 ffff 0", max_out, min_out, overrange); end
        tick(0, 1, 16'h0123, 0, 1);
        n_cmp++; if (max_out !== 16'h0123 || min_out !== 16'h0123 || overrange !== 1'b0) begin n_err++; $display("FAIL pc_sample got max=%h min=%h over=%b want 0123 0123 0", max_out, min_out, overrange); end
        n_cmp++; if (avg_out !== 16'd250 || avg_valid !== 1'b0) begin n_err++; $display("FAIL pc_avg_kept got avg=%0d valid=%b want 250 0", avg_out, avg_valid); end
        tick(0, 1, 16'h0000, 0, 0);
        tick(0, 1, 16'h0000, 0, 0);
        n_cmp++; if (avg_valid !== 1'b1 || avg_out !== 16'h4048) begin n_err++; $display("FAIL pc_window got valid=%b avg=%h want 1 4048", avg_valid, avg_out); end
        n_cmp++; if (avg_out !== m_avg[DW-1:0]) begin n_err++; $display("FAIL pc_model got %h want %h", avg_out, m_avg[DW-1:0]); end
    endtask

    task automatic test_random_windows();
        int unsigned pulses = 0;
        int unsigned exp_pulses = 0;
        int unsigned gap;
        logic [DW-1:0] s;
        bit pc;
        for (int k = 0; k < 50 * NWIN; k++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < int'(gap); g++) begin
                tick(0, 0, DW'($urandom), 0, 0);
                n_cmp++; if (avg_valid !== 1'b0) begin n_err++; $display("FAIL rnd_idle_valid got %b want 0", avg_valid); end
            end
            s  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : DW'($urandom);
            pc = ($urandom_range(0, 15) == 0);
            tick(0, 1, s, 0, pc);
            if (m_avg_valid) exp_pulses++;
            if (avg_valid === 1'b1) pulses++;
            n_cmp++; if (avg_valid !== m_avg_valid) begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", k, avg_valid, m_avg_valid); end
            n_cmp++; if (avg_out !== m_avg[DW-1:0]) begin n_err++; $display("FAIL rnd_avg[%0d] got %h want %h", k, avg_out, m_avg[DW-1:0]); end
            n_cmp++; if (max_out !== m_max[DW-1:0] || min_out !== m_min[DW-1:0] || overrange !== m_over) begin n_err++; $display("FAIL rnd_peak[%0d] got max=%h min=%h over=%b want %h %h %b", k, max_out, min_out, overrange, m_max[DW-1:0], m_min[DW-1:0], m_over); end
        end
        n_cmp++; if (pulses != 50 || exp_pulses != 50) begin n_err++; $display("FAIL rnd_pulse_count got %0d want 50", pulses); end
    endtask

    initial begin
        test_reset_settle_first_window();
        test_back_to_back();
        test_hold();
        test_mid_window_reset();
        test_peak_clear();
        test_random_windows();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
